// File: rtl/serial_word_tx_if.sv
// Word-in / bit-stream-out bundle for serial_word_tx.
// Handshake: a word transfers on a rising edge where valid_i && ready_o; data_i is
// sampled only then, and valid_i is ignored while ready_o is low.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             x_o;
  logic             bit_valid_o;
  logic             first_o;
  logic             last_o;
  logic             busy_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, x_o, bit_valid_o, first_o, last_o, busy_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, x_o, bit_valid_o, first_o, last_o, busy_o
  );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with first/last framing strobes.
// Define SERIAL_TX_NEGATE_EN to emit the two's complement of each word instead of the raw word.
module serial_word_tx #(
  parameter int WIDTH    = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_word_tx_if.slave      bus,
  output logic [1:0]           dbg_state
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);
  localparam logic [3:0]     GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;
  localparam bit             NO_GAP   = (IDLE_GAP == 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gap_cnt;
  logic             x_q;
  logic             bit_valid_q;
  logic             first_q;
  logic             last_q;
  logic             busy_q;

  logic last_bit;
  logic ready;
  logic accept;
  logic next_x;

  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
  // With no gap the last bit doubles as the accept slot, giving back-to-back words.
  assign ready    = (state == IDLE) || (NO_GAP && last_bit);
  assign accept   = ready && bus.valid_i;

`ifdef SERIAL_TX_NEGATE_EN
  // Serial negation: copy bits up to and including the first 1, invert the rest.
  logic seen_one;
  assign next_x = sreg[1] ^ seen_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_one <= 1'b0;
    end else if (accept) begin
      seen_one <= bus.data_i[0];
    end else if (state == SHIFT && !last_bit) begin
      seen_one <= seen_one | sreg[1];
    end
  end
`else
  assign next_x = sreg[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      x_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      // Bit 0 goes straight to the output register so it shows the cycle after accept.
      state       <= SHIFT;
      sreg        <= bus.data_i;
      cnt         <= '0;
      x_q         <= bus.data_i[0];
      bit_valid_q <= 1'b1;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
        end
        SHIFT: begin
          if (last_bit) begin
            x_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            if (NO_GAP) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
              busy_q  <= 1'b1;
            end
          end else begin
            sreg    <= sreg >> 1;
            cnt     <= cnt + ONE_CNT;
            x_q     <= next_x;
            first_q <= 1'b0;
            last_q  <= ((cnt + ONE_CNT) == LAST_CNT);
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o     = ready;
  assign bus.x_o         = x_q;
  assign bus.bit_valid_o = bit_valid_q;
  assign bus.first_o     = first_q;
  assign bus.last_o      = last_q;
  assign bus.busy_o      = busy_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: one instance with no idle gap, one with IDLE_GAP=3.
module tb_serial_word_tx;

`ifdef SERIAL_TX_NEGATE_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  serial_word_tx_if #(.WIDTH(8)) b0 ();
  serial_word_tx_if #(.WIDTH(8)) b3 ();
  logic [1:0] dbg0;
  logic [1:0] dbg3;

  serial_word_tx #(.WIDTH(8), .IDLE_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .dbg_state(dbg0)
  );
  serial_word_tx #(.WIDTH(8), .IDLE_GAP(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3), .dbg_state(dbg3)
  );

  logic [7:0] data;
  logic       valid0;
  logic       valid3;
  logic       sel;

  assign b0.data_i  = data;
  assign b3.data_i  = data;
  assign b0.valid_i = valid0;
  assign b3.valid_i = valid3;

  // Observed outputs of the selected instance.
  logic       m_x, m_bv, m_first, m_last, m_busy, m_ready;
  logic [1:0] m_state;
  assign m_x     = sel ? b3.x_o         : b0.x_o;
  assign m_bv    = sel ? b3.bit_valid_o : b0.bit_valid_o;
  assign m_first = sel ? b3.first_o     : b0.first_o;
  assign m_last  = sel ? b3.last_o      : b0.last_o;
  assign m_busy  = sel ? b3.busy_o      : b0.busy_o;
  assign m_ready = sel ? b3.ready_o     : b0.ready_o;
  assign m_state = sel ? dbg3           : dbg0;

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] v;
    logic [31:0] f;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] b;
    logic [31:0] g;
  } trace_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] exp_raw;
    logic [7:0] exp_neg;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic set_valid(input logic v);
    if (sel) valid3 = v;
    else     valid0 = v;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!m_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(m_ready), 32'd1);
  endtask

  // Samples n cycles starting now (at a falling edge); bit i of each field is cycle i.
  task automatic capture(input int n, input int drop_at, output trace_t tr);
    tr = '0;
    for (int i = 0; i < n; i++) begin
      tr.x[i] = m_x;
      tr.v[i] = m_bv;
      tr.f[i] = m_first;
      tr.l[i] = m_last;
      tr.r[i] = m_ready;
      tr.b[i] = m_busy;
      tr.g[i] = (m_state == 2'd2);
      if (i == drop_at) set_valid(1'b0);
      @(negedge clk);
    end
  endtask

  task automatic send_single(input logic [7:0] d, output trace_t tr);
    data = d;
    set_valid(1'b1);
    wait_ready();
    @(negedge clk);
    set_valid(1'b0);
    capture(8, -1, tr);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, 32'({m_x, m_bv, m_first, m_last, m_busy}), 32'd0);
    check({tag, "_ready"}, 32'(m_ready), 32'd1);
    check({tag, "_state"}, 32'(m_state), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t   vecs[7];
  trace_t tr;

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{8'hB4, 8'hB4, 8'h4C};
    vecs[1] = '{8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'h01};
    vecs[3] = '{8'h80, 8'h80, 8'h80};
    vecs[4] = '{8'h01, 8'h01, 8'hFF};
    vecs[5] = '{8'h06, 8'h06, 8'hFA};
    vecs[6] = '{8'h5A, 8'h5A, 8'hA6};

    // Reset held with valid asserted: nothing may start.
    reset  = 1'b0;
    sel    = 1'b0;
    data   = 8'hFF;
    valid0 = 1'b1;
    valid3 = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_idle("reset_g0");
    sel = 1'b1; #1; check_idle("reset_g3");
    valid0 = 1'b0;
    valid3 = 1'b0;
    sel    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_no_bits", 32'({m_bv, m_busy}), 32'd0);

    // Single words through the no-gap instance.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(32'(NEG ? vecs[i].exp_neg : vecs[i].exp_raw));
      send_single(vecs[i].data, tr);
      check($sformatf("v%0d_stream", i), tr.x, exp_q.pop_front());
      check($sformatf("v%0d_bit_valid", i), tr.v, 32'hFF);
      check($sformatf("v%0d_first", i), tr.f, 32'h01);
      check($sformatf("v%0d_last", i), tr.l, 32'h80);
      check($sformatf("v%0d_ready", i), tr.r, 32'h80);
      check($sformatf("v%0d_busy", i), tr.b, 32'hFF);
      check($sformatf("v%0d_after", i), 32'({m_busy, m_bv, m_first, m_last}), 32'd0);
    end

    // Back-to-back 01 then 80 with valid held high.
    data = 8'h01;
    set_valid(1'b1);
    wait_ready();
    @(negedge clk);
    data = 8'h80;
    capture(16, 8, tr);
    check("b2b_stream", tr.x, NEG ? 32'h80FF : 32'h8001);
    check("b2b_bit_valid", tr.v, 32'hFFFF);
    check("b2b_first", tr.f, 32'h0101);
    check("b2b_last", tr.l, 32'h8080);
    check("b2b_ready", tr.r, 32'h8080);
    check("b2b_busy", tr.b, 32'hFFFF);
    check("b2b_after", 32'({m_busy, m_bv}), 32'd0);

    // Two queued words through the IDLE_GAP=3 instance.
    sel = 1'b1;
    #1;
    data = 8'hA5;
    set_valid(1'b1);
    wait_ready();
    @(negedge clk);
    data = 8'h3C;
    capture(20, 12, tr);
    check("gap_stream", tr.x, NEG ? 32'hC405B : 32'h3C0A5);
    check("gap_bit_valid", tr.v, 32'hFF0FF);
    check("gap_first", tr.f, 32'h01001);
    check("gap_last", tr.l, 32'h80080);
    check("gap_ready", tr.r, 32'h00800);
    check("gap_busy", tr.b, 32'hFF7FF);
    check("gap_state", tr.g, 32'h00700);
    repeat (4) @(negedge clk);
    check_idle("gap_end");

    // Reset after bit 3 of FF, then a clean word.
    sel = 1'b0;
    #1;
    data = 8'hFF;
    set_valid(1'b1);
    wait_ready();
    @(negedge clk);
    set_valid(1'b0);
    capture(4, -1, tr);
    check("rst_pre_stream", tr.x, NEG ? 32'h1 : 32'hF);
    check("rst_pre_valid", tr.v, 32'hF);
    reset = 1'b0;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_partial", 32'({m_bv, m_busy, m_x}), 32'd0);
    send_single(8'h3C, tr);
    check("rst_next_stream", tr.x, NEG ? 32'hC4 : 32'h3C);
    check("rst_next_first", tr.f, 32'h01);
    check("rst_next_last", tr.l, 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got %0d passed of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial transmitter that feeds the bit-serial datapath, including the serial `twos_complement` negator, one bit per clock, LSB first. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single-bit stream. Framing strobes mark the first and last bit of each word so the downstream serial block can restart its per-word state. An optional inline serial negation stage emits the two's complement of each word instead of the raw word.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `IDLE_GAP`, default 0: idle cycles inserted after each word's last bit before the next word may start; legal range 0..15.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `data_i` input WIDTH: parallel word to transmit.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: block can accept a word this cycle.
- `x_o` output 1: serial bit stream, LSB first.
- `bit_valid_o` output 1: `x_o` carries a word bit this cycle.
- `first_o` output 1: current bit is bit 0 of a word.
- `last_o` output 1: current bit is bit WIDTH-1 of a word.
- `busy_o` output 1: state is not IDLE.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `ready_o`=1. On `valid_i && ready_o`, load `data_i` into the shift register, clear the bit counter, and go to SHIFT.
- SHIFT: each cycle present `sreg[0]` on `x_o`, shift right, and increment the bit counter (width clog2(WIDTH)).
  - `first_o`=1 when count==0.
  - `last_o`=1 when count==WIDTH-1.
- Leaving SHIFT, after the cycle in which count==WIDTH-1:
  - If `IDLE_GAP`==0, `ready_o`=1 in that cycle. An accept loads the next word and stays in SHIFT (back-to-back, no bubble). With no accept, go to IDLE.
  - If `IDLE_GAP`>0, go to GAP. The gap counter runs `IDLE_GAP` cycles, then the block returns to IDLE.
- `ready_o`=0 in GAP, and in SHIFT except on the last bit when `IDLE_GAP`==0. While `ready_o`=0, `valid_i` is ignored and `data_i` is not sampled.
- `busy_o`=1 in SHIFT and GAP.
- Outside SHIFT: `bit_valid_o`, `first_o`, `last_o`=0 and `x_o`=0.
- Reset mid-word abandons the word. No partial bits are emitted after reset is released.

## Timing
- Reset values: `x_o`=0, `bit_valid_o`=0, `first_o`=0, `last_o`=0, `busy_o`=0, `ready_o`=1 (combinational from state=IDLE).
- All outputs except `ready_o` are registered.
- Accept at rising edge N: bit 0 appears on `x_o` with `first_o`=1 in cycle N+1. Bit WIDTH-1 appears in cycle N+WIDTH with `last_o`=1.
- Back-to-back with `IDLE_GAP`=0: next word's bit 0 follows the previous word's bit WIDTH-1 in the very next cycle. Sustained throughput is 1 word per WIDTH cycles.
- With `IDLE_GAP`=G: minimum spacing from one word's bit 0 to the next word's bit 0 is WIDTH+G+1 cycles (includes one IDLE cycle to accept).

## Configuration
- `SERIAL_TX_NEGATE_EN` defined:
  - A serial negation stage sits in front of the output register, with a `seen_one` flag.
  - `seen_one` is cleared on each `first_o` bit. It is set after the first emitted raw bit equal to 1.
  - `x_o` = raw bit XOR `seen_one` (value before update), so the stream equals (-word) mod 2^WIDTH.
  - Latency is unchanged. 0 maps to 0; 2^(WIDTH-1) maps to itself.
- Not defined: `x_o` is the raw word bits. No negation logic is synthesized.

## Test plan
- Reset: hold `reset`=0 with `valid_i`=1 -> all outputs at reset values; `ready_o`=1; no bits emitted. Release, then accept.
- Single word, WIDTH=8, `data_i`=8'hB4:
  - `x_o` over 8 cycles = 0,0,1,0,1,1,0,1.
  - `first_o` on the 1st bit only, `last_o` on the 8th bit only.
  - `busy_o` falls after the 8th bit.
- Back-to-back, `IDLE_GAP`=0, words 8'h01 then 8'h80 with `valid_i` held high:
  - `x_o` = 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
  - No bubble between words.
  - `ready_o`=1 only in IDLE and on each last bit.
- Gap, `IDLE_GAP`=3: two queued words -> 3 cycles with `bit_valid_o`=0, plus 1 IDLE accept cycle, between the 1st word's last bit and the 2nd word's first bit.
- `SERIAL_TX_NEGATE_EN` set:
  - 8'h01 -> stream of 8'hFF (all 1s).
  - 8'h06 -> 8'hFA (0,1,0,1,1,1,1,1).
  - 8'h00 -> all 0s.
  - 8'h80 -> 8'h80.
- Reset mid-word: assert `reset` after bit 3 of 8'hFF -> `bit_valid_o`=0 immediately. After release, the next accepted word starts at bit 0 with `first_o`=1.
